code_driver: RTL and testbench
==============================

Name: code_driver

Overview:
- Self-checking stimulus master for the dual-counter unit `code`. This block drives the Slt/En inputs of `code` and reads back its Output0/Output1.
- Contract of `code`, fixed for this block. All updates are registered, so a value is visible one cycle after the En/Slt that caused it:
  - En=1, Slt=0: Output0 += 1 every cycle.
  - En=1, Slt=1: Output1 += 1 once every 4 enabled Slt=1 cycles. This uses a 2-bit phase counter that is cleared by Reset.
- code_driver runs a programmed burst of Len enabled cycles and predicts both counters with an internal model. It compares the model against the counter outputs every cycle and reports pass/fail.

Parameters:
- W, 64, counter width; must equal the Output0/Output1 width of `code`.
- LW, 16, width of the burst length field.
- DIV, 4, Output1 divide ratio; a power of two, at least 2.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  one-cycle pulse; accepted only in IDLE.
- SelCfg  in  1  Slt value to drive for the whole burst.
- Len  in  LW  number of En=1 cycles in the burst; 0 is legal.
- Slt  out  1  to code.Slt.
- En  out  1  to code.En.
- Output0  in  W  from code.Output0.
- Output1  in  W  from code.Output1.
- Busy  out  1  high from the cycle after Start is accepted until DONE.
- Done  out  1  one-cycle pulse at the end of the check.
- Pass  out  1  valid with Done and held until the next Start; 1 = no mismatch.
- ErrCnt  out  16  mismatch count for the current burst; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - Slt=0, En=0, Busy=0, Done=0, Pass=0, ErrCnt=0.
  - Model exp0=0, exp1=0, phase=0. State = IDLE.
  - The driver and `code` share Reset, so both models start at 0.
- Model update, applied on every edge where the driven En=1:
  - Slt=0: exp0 += 1, wrapping mod 2^W.
  - Slt=1: phase += 1 mod DIV; when phase wraps DIV-1 -> 0, exp1 += 1, wrapping mod 2^W.
  - The model persists across bursts and is cleared only by Reset, mirroring `code`.
- Compare:
  - Every cycle in RUN and DRAIN, Output0 is compared against exp0 and Output1 against exp1.
  - Both model registers are updated on the same edge as the counter, so they align with no skew.
  - Any inequality increments ErrCnt by 1 per cycle, not per output.
- FSM:
  - IDLE: En=0. On Start:
    - latch SelCfg -> Slt and Len -> remaining;
    - clear ErrCnt and Pass;
    - go to RUN if Len != 0, otherwise go directly to DRAIN.
  - RUN: En=1, Slt held; remaining -= 1 per cycle; when remaining == 1, the next state is DRAIN. This gives exactly Len En-high cycles.
  - DRAIN: En=0 for 1 cycle so the last registered update settles. Compare once more, then go to CHECK.
  - CHECK: Pass <= (ErrCnt == 0, including any mismatch found this cycle); Done=1 for this cycle only; go to IDLE.
- Busy = (state != IDLE).
- Start while Busy: ignored, with no queuing.
- SelCfg/Len changes mid-burst: ignored, because they were latched at Start.
- Reset mid-burst: all outputs, the model and the FSM return to reset values immediately; En drops asynchronously.
- Comparisons in IDLE are not performed.
- Wrap: at exp0 = 2^W-1, a further increment gives 0; the driver must accept Output0 = 0.
- Slt may change only in IDLE; Slt is never toggled while En=1.

Test Plan:
- Reset low 10 ns, then Start with SelCfg=0, Len=5 -> En high exactly 5 cycles; Output0 = 5 at DRAIN; Done pulse; Pass=1; ErrCnt=0; total Busy = 7 cycles.
- Start with SelCfg=1, Len=10 after the previous test -> Output1 = 2, phase = 2 at the end; Pass=1. A second burst with SelCfg=1, Len=2 -> Output1 = 3, Pass=1, showing the phase persists across bursts.
- Len=0 -> En never high; Done 2 cycles after Start; Pass=1.
- Fault injection: the bench forces Output0 +1 for 3 cycles during a Len=8 SelCfg=0 burst -> ErrCnt = 3, Pass=0 at Done.
- Reset asserted during cycle 3 of a Len=20 burst -> En=0 and Busy=0 in the same cycle; after release, Start Len=4 SelCfg=0 -> Output0 = 4, Pass=1.
- Start pulses during RUN and with Len changed mid-burst -> no effect; burst length equals the originally latched Len.

Source files
------------

// File: rtl/code_driver.sv
// Burst stimulus master for the dual-counter unit `code`: drives Slt/En for a
// programmed number of enabled cycles and checks Output0/Output1 against a local model.
`timescale 1ns/1ps
module code_driver #(
  parameter int W   = 64,
  parameter int LW  = 16,
  parameter int DIV = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          SelCfg,
  input  logic [LW-1:0] Len,
  output logic          Slt,
  output logic          En,
  input  logic [W-1:0]  Output0,
  input  logic [W-1:0]  Output1,
  output logic          Busy,
  output logic          Done,
  output logic          Pass,
  output logic [15:0]   ErrCnt
);

  localparam int PW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CHECK} state_t;

  state_t        state, state_nx;
  logic [LW-1:0] remaining;
  logic [W-1:0]  exp0, exp1;
  logic [PW-1:0] phase;
  logic          mismatch;
  logic [15:0]   errcnt_nx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = (Len != '0) ? RUN : DRAIN;
      RUN:     if (remaining == LW'(1)) state_nx = DRAIN;
      DRAIN:   state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // En is decoded straight from state so a reset drops it without waiting for a clock.
  always_comb begin
    En   = (state == RUN);
    Busy = (state != IDLE);
    Done = (state == CHECK);
  end

  always_comb begin
    mismatch  = ((state == RUN) || (state == DRAIN)) &&
                ((Output0 != exp0) || (Output1 != exp1));
    errcnt_nx = (mismatch && (ErrCnt != '1)) ? ErrCnt + 16'd1 : ErrCnt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Slt       <= 1'b0;
      remaining <= '0;
      ErrCnt    <= '0;
      Pass      <= 1'b0;
    end else begin
      if (state == IDLE && Start) begin
        Slt       <= SelCfg;
        remaining <= Len;
        ErrCnt    <= '0;
        Pass      <= 1'b0;
      end else begin
        ErrCnt <= errcnt_nx;
      end
      if (state == RUN) remaining <= remaining - LW'(1);
      // Verdict is registered on the DRAIN->CHECK edge so it is already valid while Done is high.
      if (state == DRAIN) Pass <= (errcnt_nx == '0);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exp0  <= '0;
      exp1  <= '0;
      phase <= '0;
    end else if (En) begin
      if (!Slt) begin
        exp0 <= exp0 + W'(1);
      end else begin
        phase <= phase + PW'(1);
        if (phase == PW'(DIV - 1)) exp1 <= exp1 + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_code_driver.sv
// Scoreboard bench for code_driver: a behavioural stand-in for `code` feeds the
// counters back, and a monitor checks each burst's verdict when Done pulses.
`timescale 1ns/1ps
module tb_code_driver;
  localparam int W   = 8;
  localparam int LW  = 16;
  localparam int DIV = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          SelCfg = 1'b0;
  logic [LW-1:0] Len = '0;
  logic          Slt, En, Busy, Done, Pass;
  logic [W-1:0]  Output0, Output1;
  logic [15:0]   ErrCnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  code_driver #(.W(W), .LW(LW), .DIV(DIV)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .SelCfg(SelCfg), .Len(Len),
    .Slt(Slt), .En(En), .Output0(Output0), .Output1(Output1),
    .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCnt(ErrCnt)
  );

  // Stand-in for `code`: counts enabled cycles per Slt value; Output1 is the Slt=1 count / DIV.
  int   c0 = 0, c1 = 0;
  logic fault = 1'b0;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      c0 <= 0;
      c1 <= 0;
    end else if (En) begin
      if (Slt) c1 <= c1 + 1;
      else     c0 <= c0 + 1;
    end
  end
  assign Output0 = W'(c0 + int'(fault));
  assign Output1 = W'(c1 / DIV);

  typedef struct {
    int          len;
    int          err;
    bit          pass;
    logic [63:0] e0;
    logic [63:0] e1;
  } exp_t;
  exp_t sb[$];
  longint tot0 = 0, tot1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int   en_cnt, busy_cnt;
    exp_t e;
    en_cnt = 0;
    busy_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        en_cnt = 0;
        busy_cnt = 0;
      end else begin
        if (En)   en_cnt++;
        if (Busy) busy_cnt++;
        if (Done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'(Done), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("errcnt",      64'(ErrCnt),   64'(e.err));
            chk("pass",        64'(Pass),     64'(e.pass));
            chk("en_cycles",   64'(en_cnt),   64'(e.len));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.len + 2));
            chk("output0",     64'(Output0),  e.e0);
            chk("output1",     64'(Output1),  e.e1);
          end
          en_cnt = 0;
          busy_cnt = 0;
        end
      end
    end
  end

  // Issues one burst at a negedge; optionally re-pulses Start with altered config
  // while busy, and corrupts Output0 for nfault cycles of the compare window.
  task automatic run_burst(input bit sel, input int len, input int nfault, input bit poke);
    int n;
    Start  = 1'b1;
    SelCfg = sel;
    Len    = LW'(len);
    if (sel) tot1 += len;
    else     tot0 += len;
    sb.push_back('{len, nfault, (nfault == 0), 64'(tot0 % (64'd1 << W)),
                   64'((tot1 / DIV) % (64'd1 << W))});
    @(negedge Clk);
    if (poke) begin
      Len    = LW'(len + 3);
      SelCfg = ~sel;
    end else begin
      Start = 1'b0;
    end
    @(negedge Clk);
    Start = 1'b0;
    if (nfault > 0) begin
      fault = 1'b1;
      repeat (nfault) @(negedge Clk);
      fault = 1'b0;
    end
    n = 0;
    while (Busy && n < len + 10) begin
      @(negedge Clk);
      n++;
    end
    chk("burst_end_busy", 64'(Busy), 64'd0);
  endtask

  initial begin : stim
    int len, k;
    #1;
    chk("rst_slt",    64'(Slt),    64'd0);
    chk("rst_en",     64'(En),     64'd0);
    chk("rst_busy",   64'(Busy),   64'd0);
    chk("rst_done",   64'(Done),   64'd0);
    chk("rst_pass",   64'(Pass),   64'd0);
    chk("rst_errcnt", 64'(ErrCnt), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    run_burst(1'b0, 5, 0, 1'b0);
    run_burst(1'b1, 10, 0, 1'b0);
    run_burst(1'b1, 2, 0, 1'b0);
    run_burst(1'b0, 0, 0, 1'b0);
    run_burst(1'b0, 8, 3, 1'b0);
    run_burst(1'b0, 6, 0, 1'b1);
    run_burst(1'b1, 0, 0, 1'b1);

    // Reset in the third cycle of a long burst.
    Start = 1'b1; SelCfg = 1'b0; Len = LW'(20);
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_en",     64'(En),     64'd0);
    chk("midrst_busy",   64'(Busy),   64'd0);
    chk("midrst_errcnt", 64'(ErrCnt), 64'd0);
    sb.delete();
    tot0 = 0;
    tot1 = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    run_burst(1'b0, 4, 0, 1'b0);

    // Long Slt=0 burst carries Output0 through its 2^W wrap.
    run_burst(1'b0, 300, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(0, 12);
      k   = (len >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, (len - 2 > 3) ? 3 : len - 2) : 0;
      if (len >= 2 && k == 0 && $urandom_range(0, 3) == 0) k = 0;
      run_burst(1'($urandom_range(0, 1)), len, k, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
